// File: rtl/rf_scoreboard_pkg.sv
// Shared GPR constants and WB_TO_ID_BUS field accessors for the write scoreboard.
package rf_scoreboard_pkg;

    localparam int GPR_NUM    = 32;
    localparam int GPR_ADDR_W = 5;
    localparam int SB_CNT_W   = 2;

    // WB_TO_ID_BUS layout is {rf_we, rf_waddr[4:0], rf_wdata[31:0]}
    localparam int WB_TO_ID_BUS_W  = 38;
    localparam int WB_RF_WE_BIT    = 37;
    localparam int WB_RF_WADDR_LSB = 32;

    typedef logic [GPR_ADDR_W-1:0] gpr_addr_t;

    function automatic logic wb_bus_rf_we(input logic [WB_TO_ID_BUS_W-1:0] bus);
        return bus[WB_RF_WE_BIT];
    endfunction

    function automatic gpr_addr_t wb_bus_rf_waddr(input logic [WB_TO_ID_BUS_W-1:0] bus);
        return bus[WB_RF_WADDR_LSB +: GPR_ADDR_W];
    endfunction

endpackage

// File: rtl/rf_scoreboard_if.sv
// ID/WB-side signal bundle of the register-file write scoreboard.
interface rf_scoreboard_if
    import rf_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = GPR_NUM
);
    logic                id_issue_valid;
    logic                id_issue_gr_we;
    gpr_addr_t           id_issue_dest;
    logic                id_src1_en;
    gpr_addr_t           id_src1;
    logic                id_src2_en;
    gpr_addr_t           id_src2;
    gpr_addr_t           id_dest_probe;
    logic                id_dest_probe_we;
    logic                wb_retire_we;
    gpr_addr_t           wb_retire_dest;
    logic                flush;
    logic                id_stall;
    logic [NUM_REGS-1:0] busy_vec;

    modport master (
        output id_issue_valid, id_issue_gr_we, id_issue_dest,
        output id_src1_en, id_src1, id_src2_en, id_src2,
        output id_dest_probe, id_dest_probe_we,
        output wb_retire_we, wb_retire_dest, flush,
        input  id_stall, busy_vec
    );

    modport slave (
        input  id_issue_valid, id_issue_gr_we, id_issue_dest,
        input  id_src1_en, id_src1, id_src2_en, id_src2,
        input  id_dest_probe, id_dest_probe_we,
        input  wb_retire_we, wb_retire_dest, flush,
        output id_stall, busy_vec
    );

endinterface

// File: rtl/rf_scoreboard_counter.sv
// One saturating pending-write counter for a single GPR.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    input  logic dec,
    output logic is_zero,
    output logic is_one,
    output logic is_max
);
    logic [CNT_W-1:0] cnt;

    assign is_zero = (cnt == '0);
    assign is_one  = (cnt == CNT_W'(1));
    assign is_max  = (cnt == '1);

    // inc and dec together cancel; an out-of-range step holds the count
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (inc && !dec && !is_max) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec && !inc && !is_zero) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && !clr) begin
            assert (!(dec && is_zero))
                else $warning("sb_counter: WB retire with no pending write");
            assert (!(inc && !dec && is_max))
                else $error("sb_counter: issue while pending count saturated");
        end
    end
`endif

endmodule

// File: rtl/rf_scoreboard.sv
// Counter-based GPR write scoreboard between ID and WB; raises id_stall on RAW or count overflow.
module rf_scoreboard
    import rf_scoreboard_pkg::*;
#(
    parameter int NUM_REGS  = GPR_NUM,
    parameter int CNT_W     = SB_CNT_W,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    rf_scoreboard_if.slave sb
);
    logic [NUM_REGS-1:1] inc_vec;
    logic [NUM_REGS-1:1] dec_vec;
    logic [NUM_REGS-1:1] zero_vec;
    logic [NUM_REGS-1:1] one_vec;
    logic [NUM_REGS-1:1] max_vec;
    logic [NUM_REGS-1:0] busy_now;
    logic [NUM_REGS-1:0] ovf_now;
    logic [NUM_REGS-1:0] busy_state;

    // r0 is hardwired zero: never counted, never busy, never overflows
    assign busy_now[0]   = 1'b0;
    assign ovf_now[0]    = 1'b0;
    assign busy_state[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        assign inc_vec[r] = sb.id_issue_valid && sb.id_issue_gr_we &&
                            (sb.id_issue_dest == gpr_addr_t'(r));
        assign dec_vec[r] = sb.wb_retire_we && (sb.wb_retire_dest == gpr_addr_t'(r));

        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .clr     (sb.flush),
            .inc     (inc_vec[r]),
            .dec     (dec_vec[r]),
            .is_zero (zero_vec[r]),
            .is_one  (one_vec[r]),
            .is_max  (max_vec[r])
        );

        // the last pending write retiring now is visible to ID through RF write-through
        assign busy_now[r]   = !zero_vec[r] && !(WB_BYPASS && one_vec[r] && dec_vec[r]);
        assign ovf_now[r]    = max_vec[r] && !dec_vec[r];
        assign busy_state[r] = !zero_vec[r];
    end

    assign sb.busy_vec = busy_state;
    assign sb.id_stall = (sb.id_src1_en       && busy_now[sb.id_src1]) ||
                         (sb.id_src2_en       && busy_now[sb.id_src2]) ||
                         (sb.id_dest_probe_we && ovf_now[sb.id_dest_probe]);

endmodule
